// File: rtl/ise_dispatch_rv64.sv
// ise_dispatch_rv64: two-stage decode/writeback wrapper around the rv64b_ise unit
module ise_dispatch_rv64 #(
    parameter bit SUPPORT_PACKU = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    output logic [63:0] ise_rs1,
    output logic [63:0] ise_rs2,
    output logic [4:0]  ise_imm,
    output logic        ise_op_rori,
    output logic        ise_op_roriw,
    output logic        ise_op_pack,
    output logic        ise_op_packu,
    input  logic [63:0] ise_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [3:0]  dec_op;
    logic        w_adv, d_adv, d_load;
    logic        d_valid_q, d_valid_d, d_ill_q, d_ill_d;
    logic [3:0]  d_op_q, d_op_d;
    logic [63:0] d_rs1_q, d_rs1_d, d_rs2_q, d_rs2_d;
    logic [4:0]  d_imm_q, d_imm_d, d_rd_q, d_rd_d;
    logic        w_valid_q, w_valid_d, w_ill_q, w_ill_d;
    logic [63:0] w_result_q, w_result_d;
    logic [4:0]  w_rd_q, w_rd_d;

    // op bits: [0] rori, [1] roriw, [2] pack, [3] packu
    always_comb begin
        opc = in_instr[6:0];
        f3 = in_instr[14:12];
        f7 = in_instr[31:25];
        dec_op[0] = opc == 7'b0010011 && f3 == 3'b101 && f7 == 7'b0110000;
        dec_op[1] = opc == 7'b0011011 && f3 == 3'b101 && f7 == 7'b0110000;
        dec_op[2] = opc == 7'b0110011 && f3 == 3'b100 && f7 == 7'b0000100;
        dec_op[3] = SUPPORT_PACKU && opc == 7'b0110011 && f3 == 3'b100 && f7 == 7'b0100100;
    end

    always_comb begin
        w_adv = !w_valid_q || out_ready;
        d_adv = d_valid_q && w_adv;
        in_ready = !d_valid_q || w_adv;
        d_load = in_valid && in_ready && !flush;
        d_valid_d = flush ? 1'b0 : d_load ? 1'b1 : d_adv ? 1'b0 : d_valid_q;
        d_op_d = d_load ? dec_op : d_op_q;
        d_ill_d = d_load ? dec_op == 4'b0000 : d_ill_q;
        d_rs1_d = d_load ? in_rs1 : d_rs1_q;
        d_rs2_d = d_load ? in_rs2 : d_rs2_q;
        d_imm_d = d_load ? in_instr[24:20] : d_imm_q;
        d_rd_d = d_load ? in_instr[11:7] : d_rd_q;
        w_valid_d = flush ? 1'b0 : d_adv ? 1'b1 : out_ready ? 1'b0 : w_valid_q;
        w_result_d = (d_adv && !flush) ? (d_ill_q ? 64'h0 : ise_rd) : w_result_q;
        w_rd_d = (d_adv && !flush) ? d_rd_q : w_rd_q;
        w_ill_d = (d_adv && !flush) ? d_ill_q : w_ill_q;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            d_valid_q <= 1'b0;
            d_op_q <= '0;
            d_ill_q <= 1'b0;
            d_rs1_q <= '0;
            d_rs2_q <= '0;
            d_imm_q <= '0;
            d_rd_q <= '0;
            w_valid_q <= 1'b0;
            w_result_q <= '0;
            w_rd_q <= '0;
            w_ill_q <= 1'b0;
        end else begin
            d_valid_q <= d_valid_d;
            d_op_q <= d_op_d;
            d_ill_q <= d_ill_d;
            d_rs1_q <= d_rs1_d;
            d_rs2_q <= d_rs2_d;
            d_imm_q <= d_imm_d;
            d_rd_q <= d_rd_d;
            w_valid_q <= w_valid_d;
            w_result_q <= w_result_d;
            w_rd_q <= w_rd_d;
            w_ill_q <= w_ill_d;
        end
    end

    assign ise_rs1 = d_rs1_q;
    assign ise_rs2 = d_rs2_q;
    assign ise_imm = d_imm_q;
    assign ise_op_rori = d_valid_q && d_op_q[0];
    assign ise_op_roriw = d_valid_q && d_op_q[1];
    assign ise_op_pack = d_valid_q && d_op_q[2];
    assign ise_op_packu = d_valid_q && d_op_q[3];
    assign out_valid = w_valid_q;
    assign out_result = w_result_q;
    assign out_rd = w_rd_q;
    assign out_illegal = w_ill_q;
endmodule

// File: tb/tb_ise_dispatch_rv64.sv
// tb_ise_dispatch_rv64: scoreboard bench driving a packu-enabled and a packu-disabled dispatcher in lockstep
module tb_ise_dispatch_rv64;
    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        g_clk = 1'b0, g_resetn, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_rs1, in_rs2;
    logic        a_in_ready, b_in_ready;
    logic [63:0] a_ise_rs1, a_ise_rs2, b_ise_rs1, b_ise_rs2, a_ise_rd, b_ise_rd;
    logic [4:0]  a_ise_imm, b_ise_imm, a_out_rd, b_out_rd;
    logic        a_rori, a_roriw, a_pack, a_packu, b_rori, b_roriw, b_pack, b_packu;
    logic        a_out_valid, b_out_valid, a_out_illegal, b_out_illegal;
    logic [63:0] a_out_result, b_out_result;
    int          tests = 0, fails = 0;
    exp_t        qa[$], qb[$];

    always #5 g_clk = ~g_clk;

    ise_dispatch_rv64 #(.SUPPORT_PACKU(1'b1)) u_dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .ise_rs1(a_ise_rs1), .ise_rs2(a_ise_rs2),
        .ise_imm(a_ise_imm), .ise_op_rori(a_rori), .ise_op_roriw(a_roriw), .ise_op_pack(a_pack),
        .ise_op_packu(a_packu), .ise_rd(a_ise_rd), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_result(a_out_result), .out_rd(a_out_rd), .out_illegal(a_out_illegal)
    );

    ise_dispatch_rv64 #(.SUPPORT_PACKU(1'b0)) u_np (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .ise_rs1(b_ise_rs1), .ise_rs2(b_ise_rs2),
        .ise_imm(b_ise_imm), .ise_op_rori(b_rori), .ise_op_roriw(b_roriw), .ise_op_pack(b_pack),
        .ise_op_packu(b_packu), .ise_rd(b_ise_rd), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_result(b_out_result), .out_rd(b_out_rd), .out_illegal(b_out_illegal)
    );

    // Stand-in for the combinational rv64b_ise unit; idle output is deliberately nonzero.
    function automatic logic [63:0] ise_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                           input logic [4:0] s);
        logic [127:0] r;
        logic [63:0]  w;
        r = {a, a} >> s;
        w = {a[31:0], a[31:0]} >> s;
        return op[0] ? r[63:0] : op[1] ? {32'h0, w[31:0]} : op[2] ? {b[31:0], a[31:0]} :
               op[3] ? {b[63:32], a[63:32]} : ~(a ^ b);
    endfunction

    always_comb a_ise_rd = ise_fn({a_packu, a_pack, a_roriw, a_rori}, a_ise_rs1, a_ise_rs2, a_ise_imm);
    always_comb b_ise_rd = ise_fn({b_packu, b_pack, b_roriw, b_rori}, b_ise_rs1, b_ise_rs2, b_ise_imm);

    function automatic exp_t model(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b, input bit sup);
        logic [127:0] r;
        logic [63:0]  w;
        exp_t         e;
        r = {a, a} >> i[24:20];
        w = {a[31:0], a[31:0]} >> i[24:20];
        e.rd = i[11:7];
        e.ill = 1'b0;
        if (i[6:0] == 7'h13 && i[14:12] == 3'd5 && i[31:26] == 6'b011000 && !i[25]) e.res = r[63:0];
        else if (i[6:0] == 7'h1b && i[14:12] == 3'd5 && i[31:25] == 7'h30) e.res = {32'h0, w[31:0]};
        else if (i[6:0] == 7'h33 && i[14:12] == 3'd4 && i[31:25] == 7'h04) e.res = {b[31:0], a[31:0]};
        else if (i[6:0] == 7'h33 && i[14:12] == 3'd4 && i[31:25] == 7'h24 && sup) e.res = {b[63:32], a[63:32]};
        else begin
            e.res = 64'h0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: return {7'h30, w[24:15], 3'd5, w[11:7], 7'h13};
            1: return {7'h31, w[24:15], 3'd5, w[11:7], 7'h13};
            2: return {7'h30, w[24:15], 3'd5, w[11:7], 7'h1b};
            3: return {7'h04, w[24:15], 3'd4, w[11:7], 7'h33};
            4: return {7'h24, w[24:15], 3'd4, w[11:7], 7'h33};
            5: return w;
            default: return {7'h04, w[24:15], 3'd4, w[11:7], 7'h33} ^ (32'h1 << $urandom_range(0, 31));
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic put(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_instr = i;
        in_rs1 = a;
        in_rs2 = b;
    endtask

    always @(negedge g_clk)
        if (g_resetn && !flush && in_valid && a_in_ready) begin
            qa.push_back(model(in_instr, in_rs1, in_rs2, 1'b1));
            qb.push_back(model(in_instr, in_rs1, in_rs2, 1'b0));
        end

    logic        prev_hold = 1'b0;
    logic [63:0] prev_res = '0;
    always @(negedge g_clk) begin
        if (!g_resetn || flush) begin
            qa.delete();
            qb.delete();
            prev_hold = 1'b0;
        end else begin
            exp_t e;
            if (prev_hold) begin
                chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
                chk("bp_hold_result", a_out_result, prev_res);
            end
            if (a_out_valid && out_ready) begin
                tests++;
                if (qa.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out_a: result %h with empty scoreboard", a_out_result);
                end else begin
                    e = qa.pop_front();
                    if ({a_out_result, a_out_rd, a_out_illegal} !== e) begin
                        fails++;
                        $display("FAIL retire_a: got res=%h rd=%0d ill=%b expected res=%h rd=%0d ill=%b",
                                 a_out_result, a_out_rd, a_out_illegal, e.res, e.rd, e.ill);
                    end
                end
            end
            if (b_out_valid && out_ready) begin
                tests++;
                if (qb.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out_b: result %h with empty scoreboard", b_out_result);
                end else begin
                    e = qb.pop_front();
                    if ({b_out_result, b_out_rd, b_out_illegal} !== e) begin
                        fails++;
                        $display("FAIL retire_b: got res=%h rd=%0d ill=%b expected res=%h rd=%0d ill=%b",
                                 b_out_result, b_out_rd, b_out_illegal, e.res, e.rd, e.ill);
                    end
                end
            end
            prev_hold = a_out_valid && !out_ready;
            prev_res = a_out_result;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ill_i [3];
        int          n;
        g_resetn = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_instr = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        repeat (3) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_result", a_out_result, 64'd0);
        chk("rst_out_rd", 64'(a_out_rd), 64'd0);
        chk("rst_out_illegal", 64'(a_out_illegal), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_ise", {a_ise_rs1 | a_ise_rs2, a_ise_imm, a_rori, a_roriw, a_pack, a_packu} == '0 ? 64'd0 : 64'd1, 64'd0);

        tick();
        put(32'h60435293, 64'h0123456789ABCDEF, {$urandom, $urandom});
        @(negedge g_clk);
        chk("rori_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge g_clk);
        chk("rori_lat_d_outvalid", 64'(a_out_valid), 64'd0);
        chk("rori_d_op", 64'({a_packu, a_pack, a_roriw, a_rori}), 64'd1);
        chk("rori_d_imm", 64'(a_ise_imm), 64'd4);
        tick();
        @(negedge g_clk);
        chk("rori_lat_w_outvalid", 64'(a_out_valid), 64'd1);
        chk("rori_result", a_out_result, 64'hF0123456789ABCDE);
        chk("rori_rd", 64'(a_out_rd), 64'd5);
        chk("rori_illegal", 64'(a_out_illegal), 64'd0);

        tick();
        put({7'h30, 5'd8, 5'd1, 3'd5, 5'd9, 7'h1b}, 64'hFFFFFFFF89ABCDEF, 64'h0);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge g_clk);
        chk("roriw_result", a_out_result, 64'h00000000EF89ABCD);

        tick();
        put({7'h04, 10'd0, 3'd4, 5'd3, 7'h33}, 64'h1111111122222222, 64'h3333333344444444);
        @(negedge g_clk);
        chk("pack_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        put({7'h24, 10'd0, 3'd4, 5'd4, 7'h33}, 64'h1111111122222222, 64'h3333333344444444);
        @(negedge g_clk);
        chk("packu_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge g_clk);
        chk("pack_result", a_out_result, 64'h4444444422222222);
        tick();
        @(negedge g_clk);
        chk("packu_result", a_out_result, 64'h3333333311111111);
        chk("packu_np_illegal", 64'(b_out_illegal), 64'd1);
        chk("packu_np_result", b_out_result, 64'd0);

        tick();
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (n < 3) put(gen(), {$urandom, $urandom}, {$urandom, $urandom});
            @(negedge g_clk);
            if (a_in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        @(negedge g_clk);
        chk("bp_accepted", 64'(n), 64'd2);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();

        ill_i[0] = {7'h31, 5'd3, 5'd2, 3'd5, 5'd6, 7'h13};
        ill_i[1] = 32'h00000013;
        ill_i[2] = {7'h24, 5'd1, 5'd2, 3'd4, 5'd7, 7'h33};
        for (int k = 0; k < 3; k++) begin
            put(ill_i[k], {$urandom, $urandom}, {$urandom, $urandom});
            tick();
            in_valid = 1'b0;
            @(negedge g_clk);
            chk("ill_d_ops", 64'(k < 2 ? {a_packu, a_pack, a_roriw, a_rori} : {b_packu, b_pack, b_roriw, b_rori}), 64'd0);
            tick();
            @(negedge g_clk);
            chk("ill_flag", 64'(k < 2 ? a_out_illegal : b_out_illegal), 64'd1);
            chk("ill_result", k < 2 ? a_out_result : b_out_result, 64'd0);
            tick();
        end

        out_ready = 1'b0;
        put(gen(), {$urandom, $urandom}, {$urandom, $urandom});
        tick();
        put(gen(), {$urandom, $urandom}, {$urandom, $urandom});
        tick();
        put(gen(), {$urandom, $urandom}, {$urandom, $urandom});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge g_clk);
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_d_ops", 64'({a_packu, a_pack, a_roriw, a_rori}), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        put({7'h04, 10'd0, 3'd4, 5'd3, 7'h33}, {$urandom, $urandom}, {$urandom, $urandom});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge g_clk);
        chk("flush_drop_d", 64'({a_packu, a_pack, a_roriw, a_rori}), 64'd0);
        tick();
        @(negedge g_clk);
        chk("flush_drop_w", 64'(a_out_valid), 64'd0);

        tick();
        put({7'h04, 10'd0, 3'd4, 5'd3, 7'h33}, {$urandom, $urandom}, {$urandom, $urandom});
        tick();
        put({7'h30, 10'd0, 3'd5, 5'd8, 7'h13}, {$urandom, $urandom}, {$urandom, $urandom});
        tick();
        in_valid = 1'b0;
        g_resetn = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mrst_out_result", a_out_result, 64'd0);
        chk("mrst_d_ops", 64'({a_packu, a_pack, a_roriw, a_rori}), 64'd0);
        @(negedge g_clk);
        tick();
        g_resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            chk("mrst_no_stale", 64'(a_out_valid), 64'd0);
        end

        for (int c = 0; c < 2000; c++) begin
            tick();
            put(gen(), {$urandom, $urandom}, {$urandom, $urandom});
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 49) == 0;
        end
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        @(negedge g_clk);
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
